row_scan_sequencer: RTL and testbench
=====================================

# row_scan_sequencer

Controller that drives the serial sequence-detector datapath (`Top`: address in, `Odd` out) across a range of ROM rows without bench intervention. For each row it:
- presents the row address;
- pulses the detector reset;
- waits a fixed scan window;
- captures the detector's `Odd` flag into a per-row result mask and running count.

Sits between a host/CPU-style start interface and the detector instance.

## Interface
Parameters:
- `ADDR_W`, 5: row-address width; row space is 2^ADDR_W rows.
- `RST_CYCLES`, 2: cycles `det_rst_n` is held low before each row scan (≥1).
- `SCAN_CYCLES`, 19: cycles allowed for the detector to consume one row before `Odd` is sampled (≥1).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a scan; honoured only in IDLE.
- `abort`  in  1  synchronous cancel of an in-progress scan.
- `first_addr`  in  ADDR_W  first row; sampled on an accepted start.
- `last_addr`  in  ADDR_W  last row, inclusive; sampled on an accepted start.
- `det_addr`  out  ADDR_W  row address to detector.
- `det_rst_n`  out  1  detector reset, active-low.
- `det_odd`  in  1  detector `Odd` flag.
- `busy`  out  1  high from the cycle after start through the final SAMPLE.
- `done`  out  1  one-cycle pulse on completion; not asserted on abort.
- `odd_mask`  out  2^ADDR_W  bit i = captured `det_odd` for row i in the last scan.
- `odd_count`  out  ADDR_W+1  number of rows in the last scan with `det_odd`=1.

## Operation
- All outputs are registered. Reset values:
  - `det_addr`=0, `det_rst_n`=0, `busy`=0, `done`=0, `odd_mask`=0, `odd_count`=0.
  - State IDLE; internal counters 0.
- States: IDLE, CLEAR, SCAN, SAMPLE, DONE.
- IDLE
  - `det_rst_n`=0, so the detector is held quiet.
  - On `start`=1: latch `first_addr`/`last_addr`, set `det_addr`=`first_addr`, clear `odd_mask` and `odd_count`, set `busy`=1, go to CLEAR.
- CLEAR
  - `det_rst_n`=0 for RST_CYCLES cycles, then go to SCAN.
- SCAN
  - `det_rst_n`=1 for SCAN_CYCLES cycles; `det_addr` is stable. Then go to SAMPLE.
- SAMPLE (1 cycle)
  - `odd_mask[det_addr]` <= `det_odd`; `odd_count` <= `odd_count` + `det_odd`.
  - If `det_addr`==`last_addr`: go to DONE.
  - Else: `det_addr` <= `det_addr`+1, modulo 2^ADDR_W, and go to CLEAR.
- DONE (1 cycle)
  - `done`=1, `busy`=0, `det_rst_n`=0, then go to IDLE.
- Range and wrap-around
  - Rows scanned N = ((`last_addr` − `first_addr`) mod 2^ADDR_W) + 1.
  - `last_addr` < `first_addr` wraps through 2^ADDR_W−1 to 0.
  - `first_addr`==`last_addr` scans exactly one row.
- `start` while not in IDLE is ignored: no re-latch, no result change.
- `abort` in CLEAR/SCAN/SAMPLE/DONE:
  - Next state IDLE, `busy`=0, `det_rst_n`=0, no `done`.
  - `odd_mask`/`odd_count` keep partial results. A SAMPLE coinciding with `abort` does not update them.
- Simultaneous `start`+`abort` in IDLE: `abort` wins and `start` is dropped.
- Async reset mid-scan: all state and outputs return to their reset values immediately, results included.

## Timing
- Accepted start at edge 0:
  - CLEAR occupies cycles 1..RST_CYCLES.
  - SCAN occupies cycles RST_CYCLES+1..RST_CYCLES+SCAN_CYCLES.
  - SAMPLE occupies cycle RST_CYCLES+SCAN_CYCLES+1.
- Per-row period P = RST_CYCLES+SCAN_CYCLES+1, which is 22 with the defaults.
- `done` is high in cycle N·P+1 after start; `busy` is high in cycles 1..N·P.
- `det_odd` is sampled only on the SAMPLE edge, and only the final value in the window matters.
- Earliest next accepted start: the cycle after DONE, back in IDLE.

## Structure
- Shared package holds:
  - the state enum (IDLE, CLEAR, SCAN, SAMPLE, DONE);
  - ADDR_W;
  - default RST_CYCLES/SCAN_CYCLES constants, also used by the detector testbenches.
- One natural sub-module: `phase_timer`, a loadable down-counter that reports terminal count and serves both CLEAR and SCAN.
- Everything else stays flat in `row_scan_sequencer`.

## Test plan
Defaults for all scenarios; the bench models `det_odd` as a per-row table.
- Single row: start with `first_addr`=3, `last_addr`=3, table[3]=0 -> `det_addr`=3 throughout, `done` at cycle 23, `odd_mask`=0, `odd_count`=0.
- Single odd row: `first_addr`=`last_addr`=24, table[24]=1 -> `odd_mask`=32'h0100_0000, `odd_count`=1, `done` at cycle 23.
- Wrap range: `first_addr`=30, `last_addr`=1, table=1 for rows 31 and 0 -> `det_addr` sequence 30,31,0,1; `odd_mask`=32'h8000_0001; `odd_count`=2; `done` at cycle 89.
- Start while busy: second start with different addresses during SCAN of row 15 -> ignored, original range completes, results unchanged by the second start.
- Abort: abort during SCAN of the 2nd row of 3..5 -> `busy`=0 next cycle, no `done`, `odd_mask` holds only the row-3 result, `det_rst_n`=0.
- Async reset: `rst_n` low mid-SCAN -> all outputs at reset values immediately; a new start after release behaves as the single-row case.

Source files
------------

// File: rtl/row_scan_sequencer_pkg.sv
// Shared types and default timing for the row scan sequencer.
// Defaults are also used by the detector testbenches.
package row_scan_sequencer_pkg;

   localparam int ADDR_W_DEF      = 5;
   localparam int RST_CYCLES_DEF  = 2;
   localparam int SCAN_CYCLES_DEF = 19;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SCAN,
      SAMPLE,
      DONE
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/row_scan_sequencer_timer.sv
// phase_timer: loadable down-counter shared by the CLEAR and SCAN phases.
// Ports: clk, rst_n, load/value (reload), tc (count is zero).
module phase_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         tc
);

   logic [W-1:0] cnt;

   // Loading N-1 makes a phase last N cycles; the count then
   // parks at zero until the next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/row_scan_sequencer.sv
// Walks a row range: per row, reset detector, scan, sample det_odd.
// Ports: clk, rst_n, start/abort, first/last_addr, detector side
// (det_addr, det_rst_n, det_odd), busy, done, odd_mask, odd_count.
module row_scan_sequencer
   import row_scan_sequencer_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int RST_CYCLES  = RST_CYCLES_DEF,
   parameter int SCAN_CYCLES = SCAN_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_W-1:0]     first_addr,
   input  logic [ADDR_W-1:0]     last_addr,
   output logic [ADDR_W-1:0]     det_addr,
   output logic                  det_rst_n,
   input  logic                  det_odd,
   output logic                  busy,
   output logic                  done,
   output logic [(1<<ADDR_W)-1:0] odd_mask,
   output logic [ADDR_W:0]       odd_count
);

   localparam int MAXC = max_int(RST_CYCLES, SCAN_CYCLES);
   localparam int TW   = $clog2(MAXC + 1);
   localparam logic [TW-1:0] RST_LD  = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] SCAN_LD = TW'(SCAN_CYCLES - 1);

   state_t            state;
   logic [ADDR_W-1:0] last_q;
   logic              accept;
   logic              is_last;
   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_tc;

   // abort beats start when both arrive in IDLE
   assign accept  = (state == IDLE) && start && !abort;
   assign is_last = (det_addr == last_q);

   // Timer reloads on the edge that enters CLEAR or SCAN.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = RST_LD;
      case (state)
         IDLE:   tmr_load = accept;
         CLEAR: begin
            if (tmr_tc) begin
               tmr_load = 1'b1;
               tmr_val  = SCAN_LD;
            end
         end
         SAMPLE: tmr_load = !is_last;
         default: ;
      endcase
   end

   phase_timer #(
      .W (TW)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .value (tmr_val),
      .tc    (tmr_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_q    <= '0;
         det_addr  <= '0;
         det_rst_n <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         odd_mask  <= '0;
         odd_count <= '0;
      end else begin
         done <= 1'b0;
         if (abort && state != IDLE) begin
            // partial results are kept
            state     <= IDLE;
            busy      <= 1'b0;
            det_rst_n <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  det_rst_n <= 1'b0;
                  if (accept) begin
                     last_q    <= last_addr;
                     det_addr  <= first_addr;
                     odd_mask  <= '0;
                     odd_count <= '0;
                     busy      <= 1'b1;
                     state     <= CLEAR;
                  end
               end
               CLEAR: begin
                  if (tmr_tc) begin
                     det_rst_n <= 1'b1;
                     state     <= SCAN;
                  end
               end
               SCAN: begin
                  if (tmr_tc) begin
                     state <= SAMPLE;
                  end
               end
               SAMPLE: begin
                  // detector stays out of reset until the
                  // sample edge so Odd is still valid here
                  odd_mask[det_addr] <= det_odd;
                  odd_count <= odd_count + (ADDR_W+1)'(det_odd);
                  det_rst_n <= 1'b0;
                  if (is_last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     det_addr <= det_addr + ADDR_W'(1);
                     state    <= CLEAR;
                  end
               end
               DONE: begin
                  det_rst_n <= 1'b0;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Directed bench for row_scan_sequencer with a table-driven det_odd.
// Covers range scans, wrap, start-while-busy, abort and async reset.
module tb_row_scan_sequencer;
   import row_scan_sequencer_pkg::*;

   localparam int AW = ADDR_W_DEF;
   localparam int RC = RST_CYCLES_DEF;
   localparam int SC = SCAN_CYCLES_DEF;
   localparam int P  = RC + SC + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] first_addr = '0;
   logic [AW-1:0] last_addr = '0;
   logic [AW-1:0] det_addr;
   logic          det_rst_n;
   logic          det_odd;
   logic          busy;
   logic          done;
   logic [31:0]   odd_mask;
   logic [AW:0]   odd_count;
   logic [31:0]   odd_tab = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign det_odd = odd_tab[det_addr];

   row_scan_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .det_addr   (det_addr),
      .det_rst_n  (det_rst_n),
      .det_odd    (det_odd),
      .busy       (busy),
      .done       (done),
      .odd_mask   (odd_mask),
      .odd_count  (odd_count)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " det_addr"}, 64'(det_addr), 64'd0);
      chk({nm, " det_rst_n"}, 64'(det_rst_n), 64'd0);
      chk({nm, " busy"}, 64'(busy), 64'd0);
      chk({nm, " done"}, 64'(done), 64'd0);
      chk({nm, " odd_mask"}, 64'(odd_mask), 64'd0);
      chk({nm, " odd_count"}, 64'(odd_count), 64'd0);
   endtask

   // kind: 0 plain, 1 stray start at ev, 2 abort at ev, 3 rst_n at ev
   task automatic do_scan(input string nm, input logic [4:0] f,
                          input logic [4:0] l, input logic [31:0] tab,
                          input logic [31:0] exp_mask, input int exp_cnt,
                          input int exp_done, input int ev, input int kind);
      logic [4:0] d;
      logic [4:0] ea;
      int n, ph, got, seq_bad, bsy_bad, lim;
      d = l - f;
      n = int'(d) + 1;
      got = -1;
      seq_bad = 0;
      bsy_bad = 0;
      lim = n * P + 45;
      odd_tab = tab;
      @(negedge clk);
      first_addr = f;
      last_addr = l;
      start = 1'b1;
      for (int k = 1; k <= lim; k++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         first_addr = ~f;
         last_addr = ~l;
         if (got < 0 && k <= n * P && (kind < 2 || k <= ev)) begin
            ph = (k - 1) % P;
            ea = f + 5'((k - 1) / P);
            if (det_addr !== ea) seq_bad++;
            if (ph < RC && det_rst_n !== 1'b0) seq_bad++;
            if (ph >= RC && ph < RC + SC && det_rst_n !== 1'b1) seq_bad++;
            if (busy !== 1'b1 || done !== 1'b0) bsy_bad++;
         end
         if (done === 1'b1 && got < 0) begin
            got = k;
            if (busy !== 1'b0) bsy_bad++;
         end
         if (kind == 1 && k == ev) begin
            start = 1'b1;
            first_addr = 5'd0;
            last_addr = 5'd0;
         end
         if (kind == 2 && k == ev) abort = 1'b1;
         if (kind == 2 && k == ev + 1) begin
            chk({nm, " abort busy"}, 64'(busy), 64'd0);
            chk({nm, " abort det_rst_n"}, 64'(det_rst_n), 64'd0);
         end
         if (kind == 3 && k == ev) begin
            chk({nm, " pre-reset mask"}, 64'(odd_mask), 64'(exp_mask));
            #2 rst_n = 1'b0;
            #1 chk_reset_vals({nm, " async"});
            @(negedge clk);
            rst_n = 1'b1;
            break;
         end
         if (kind != 2 && got > 0) break;
         if (kind == 2 && k == ev + 40) break;
      end
      if (kind != 3) begin
         chk({nm, " addr/rst seq"}, 64'(seq_bad), 64'd0);
         chk({nm, " busy window"}, 64'(bsy_bad), 64'd0);
         chk({nm, " done cycle"}, 64'(got), 64'(exp_done));
         chk({nm, " odd_mask"}, 64'(odd_mask), 64'(exp_mask));
         chk({nm, " odd_count"}, 64'(odd_count), 64'(exp_cnt));
      end
   endtask

   typedef struct {
      string       nm;
      logic [4:0]  f;
      logic [4:0]  l;
      logic [31:0] tab;
      logic [31:0] mask;
      int          cnt;
      int          dcyc;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{"single", 5'd3, 5'd3, 32'h0000_0000, 32'h0, 0, 23};
      vecs[1] = '{"single odd", 5'd24, 5'd24, 32'h0100_0000,
                  32'h0100_0000, 1, 23};
      vecs[2] = '{"wrap", 5'd30, 5'd1, 32'h8000_0001,
                  32'h8000_0001, 2, 89};
      vecs[3] = '{"range", 5'd10, 5'd12, 32'hFFFF_F7FF ^ 32'hFFFF_FFFF
                  | 32'h0000_0800, 32'h0000_0800, 1, 67};
      vecs[4] = '{"full", 5'd0, 5'd31, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 32, 705};

      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i])
         do_scan(vecs[i].nm, vecs[i].f, vecs[i].l, vecs[i].tab,
                 vecs[i].mask, vecs[i].cnt, vecs[i].dcyc, 0, 0);

      // stray start during SCAN of row 15 must be ignored
      do_scan("busy start", 5'd15, 5'd16, 32'h0000_8001,
              32'h0000_8000, 1, 45, 10, 1);

      // abort during SCAN of row 4 keeps only the row 3 result
      do_scan("abort", 5'd3, 5'd5, 32'h0000_0018,
              32'h0000_0008, 1, -1, 30, 2);

      // start and abort together in IDLE: abort wins
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      first_addr = 5'd7;
      last_addr = 5'd7;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start+abort busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("start+abort det_rst_n", 64'(det_rst_n), 64'd0);
      chk("start+abort mask kept", 64'(odd_mask), 64'h8);

      // async reset during SCAN of row 21 after row 20 was sampled
      do_scan("rst", 5'd20, 5'd21, 32'h0010_0000,
              32'h0010_0000, 1, 0, 30, 3);
      do_scan("after rst", 5'd3, 5'd3, 32'h0000_0000,
              32'h0, 0, 23, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
